// File: rtl/packet_stat_counter.sv
// Per-port packet framing checker and counter driving six registered seven-segment digits.
// Ingress is port 0 (hex1..hex3), egress is port 1 (hex4..hex6).
`timescale 1ns / 1ps

module packet_stat_counter #(
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter int unsigned ACT_HOLD       = 2_500_000
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       clear_stats,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       out_valid,
  input  logic       out_sop,
  input  logic       out_eop,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5,
  output logic [7:0] hex6,
  output logic [7:0] err_in,
  output logic [7:0] err_out
);

  localparam int unsigned RefW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned ActW = $clog2(ACT_HOLD + 1);

  typedef enum logic {StIdle, StPkt} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

  logic [1:0]  valid, sop, eop;
  logic [11:0] cnt   [2];
  logic [7:0]  err   [2];
  logic [1:0]  act;

  assign valid = {out_valid, in_valid};
  assign sop   = {out_sop, in_sop};
  assign eop   = {out_eop, in_eop};

  for (genvar p = 0; p < 2; p++) begin : g_port
    state_e          state_q, state_d;
    logic            count_pkt, count_err;
    logic [11:0]     cnt_q;
    logic [7:0]      err_q;
    logic [ActW-1:0] act_q;

    always_comb begin
      state_d   = state_q;
      count_pkt = 1'b0;
      count_err = 1'b0;
      if (clear_stats) begin
        state_d = StIdle;
      end else if (valid[p]) begin
        unique case (state_q)
          StIdle: begin
            if (sop[p] && eop[p]) begin
              count_pkt = 1'b1;
            end else if (sop[p]) begin
              state_d = StPkt;
            end else begin
              count_err = 1'b1;
            end
          end
          StPkt: begin
            // A fresh sop abandons the open packet; the new one may close on the same beat.
            if (sop[p]) count_err = 1'b1;
            if (eop[p]) begin
              count_pkt = 1'b1;
              state_d   = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        err_q <= '0;
        act_q <= '0;
      end else if (clear_stats) begin
        cnt_q <= '0;
        err_q <= '0;
        act_q <= '0;
      end else begin
        if (count_pkt) cnt_q <= cnt_q + 12'd1;
        if (count_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        if (count_pkt) begin
          act_q <= ACT_HOLD[ActW-1:0];
        end else if (act_q != '0) begin
          act_q <= act_q - 1'b1;
        end
      end
    end

    assign cnt[p] = cnt_q;
    assign err[p] = err_q;
    assign act[p] = (act_q != '0);
  end

  logic [RefW-1:0] refresh_q;
  logic            refresh_tick;
  logic [6:0]      dig_in_q  [3];
  logic [6:0]      dig_out_q [3];

  assign refresh_tick = (refresh_q == RefW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      refresh_q <= '0;
    end else if (refresh_tick) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Snapshot uses pre-edge counts, so a packet sampled on the tick edge shows next refresh.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        dig_in_q[i]  <= 7'h3F;
        dig_out_q[i] <= 7'h3F;
      end
    end else if (refresh_tick) begin
      dig_in_q[0]  <= seg7(cnt[0][11:8]);
      dig_in_q[1]  <= seg7(cnt[0][7:4]);
      dig_in_q[2]  <= seg7(cnt[0][3:0]);
      dig_out_q[0] <= seg7(cnt[1][11:8]);
      dig_out_q[1] <= seg7(cnt[1][7:4]);
      dig_out_q[2] <= seg7(cnt[1][3:0]);
    end
  end

  assign hex1    = {1'b0, dig_in_q[0]};
  assign hex2    = {1'b0, dig_in_q[1]};
  assign hex3    = {act[0], dig_in_q[2]};
  assign hex4    = {1'b0, dig_out_q[0]};
  assign hex5    = {1'b0, dig_out_q[1]};
  assign hex6    = {act[1], dig_out_q[2]};
  assign err_in  = err[0];
  assign err_out = err[1];

endmodule

// File: tb/tb_packet_stat_counter.sv
// Randomized and directed bench for packet_stat_counter; a per-cycle reference model feeds
// a scoreboard queue that an independent monitor drains after every clock edge.
`timescale 1ns / 1ps

module tb_packet_stat_counter;

  localparam int unsigned R = 16;
  localparam int unsigned H = 4;
  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                          7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                                          7'h79, 7'h71};

  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  logic clear_stats = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic out_valid = 1'b0, out_sop = 1'b0, out_eop = 1'b0;
  logic [7:0] hex1, hex2, hex3, hex4, hex5, hex6, err_in, err_out;

  always #5 clk50 = ~clk50;

  packet_stat_counter #(
    .REFRESH_CYCLES(R),
    .ACT_HOLD      (H)
  ) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .clear_stats(clear_stats),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .hex6       (hex6),
    .err_in     (err_in),
    .err_out    (err_out)
  );

  typedef struct packed {
    logic [7:0] h1, h2, h3, h4, h5, h6, ei, eo;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: edge index since reset, counts as plain integers.
  int t;
  int cnt[2];
  int errc[2];
  int disp[2];
  int last[2];
  bit inpkt[2];
  bit has_act[2];
  bit act_now[2];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.h1 = {1'b0, SEG_TBL[(disp[0] >> 8) & 15]};
    o.h2 = {1'b0, SEG_TBL[(disp[0] >> 4) & 15]};
    o.h3 = {act_now[0], SEG_TBL[disp[0] & 15]};
    o.h4 = {1'b0, SEG_TBL[(disp[1] >> 8) & 15]};
    o.h5 = {1'b0, SEG_TBL[(disp[1] >> 4) & 15]};
    o.h6 = {act_now[1], SEG_TBL[disp[1] & 15]};
    o.ei = 8'(errc[0]);
    o.eo = 8'(errc[1]);
    return o;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int p = 0; p < 2; p++) begin
      cnt[p] = 0; errc[p] = 0; disp[p] = 0; last[p] = 0;
      inpkt[p] = 1'b0; has_act[p] = 1'b0; act_now[p] = 1'b0;
    end
  endtask

  task automatic cycle(input bit iv, input bit is, input bit ie, input bit ov, input bit os,
                       input bit oe, input bit clr, input bit rst);
    bit v[2], s[2], e[2];
    bit counted;
    @(negedge clk50);
    reset_n = rst;
    in_valid = iv; in_sop = is; in_eop = ie;
    out_valid = ov; out_sop = os; out_eop = oe;
    clear_stats = clr;
    v[0] = iv; s[0] = is; e[0] = ie;
    v[1] = ov; s[1] = os; e[1] = oe;
    if (!rst) begin
      model_reset();
    end else begin
      if (t % R == R - 1) begin
        disp[0] = cnt[0];
        disp[1] = cnt[1];
      end
      for (int p = 0; p < 2; p++) begin
        counted = 1'b0;
        if (clr) begin
          cnt[p] = 0; errc[p] = 0; inpkt[p] = 1'b0; has_act[p] = 1'b0;
        end else if (v[p]) begin
          if (!inpkt[p]) begin
            if (s[p] && e[p]) counted = 1'b1;
            else if (s[p]) inpkt[p] = 1'b1;
            else if (errc[p] < 255) errc[p]++;
          end else begin
            if (s[p] && errc[p] < 255) errc[p]++;
            if (e[p]) begin
              counted = 1'b1;
              inpkt[p] = 1'b0;
            end
          end
        end
        if (counted) begin
          cnt[p] = (cnt[p] + 1) % 4096;
          has_act[p] = 1'b1;
          last[p] = t;
        end
        act_now[p] = has_act[p] && (t - last[p] < int'(H));
      end
      t++;
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic async_reset();
    @(posedge clk50);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_hex1", hex1, 8'h3F);
    chk("rst_hex2", hex2, 8'h3F);
    chk("rst_hex3", hex3, 8'h3F);
    chk("rst_hex4", hex4, 8'h3F);
    chk("rst_hex5", hex5, 8'h3F);
    chk("rst_hex6", hex6, 8'h3F);
    chk("rst_err_in", err_in, 8'h00);
    chk("rst_err_out", err_out, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one scoreboard entry per clock edge, compared just after the edge.
  initial begin
    obs_t ex, ac;
    forever begin
      @(posedge clk50);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        ac = '{hex1, hex2, hex3, hex4, hex5, hex6, err_in, err_out};
        chk("sb_hex1", ac.h1, ex.h1);
        chk("sb_hex2", ac.h2, ex.h2);
        chk("sb_hex3", ac.h3, ex.h3);
        chk("sb_hex4", ac.h4, ex.h4);
        chk("sb_hex5", ac.h5, ex.h5);
        chk("sb_hex6", ac.h6, ex.h6);
        chk("sb_err_in", ac.ei, ex.ei);
        chk("sb_err_out", ac.eo, ex.eo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    async_reset();

    // 26 single-beat ingress packets alongside 3 two-beat egress packets.
    for (int i = 0; i < 26; i++) begin
      cycle(1, 1, 1, i < 6, (i < 6) && (i % 2 == 0), (i < 6) && (i % 2 == 1), 0, 1);
    end
    idle(20);
    chk("cnt_hex1", hex1, 8'h3F);
    chk("cnt_hex2", hex2, 8'h06);
    chk("cnt_hex3", hex3, 8'h77);
    chk("cnt_hex4", hex4, 8'h3F);
    chk("cnt_hex5", hex5, 8'h3F);
    chk("cnt_hex6", hex6, 8'h4F);

    // Wrap: 4097 packets from zero shows 001.
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4097; i++) cycle(1, 1, 1, 0, 0, 0, 0, 1);
    idle(20);
    chk("wrap_hex1", hex1, 8'h3F);
    chk("wrap_hex2", hex2, 8'h3F);
    chk("wrap_hex3", hex3, 8'h06);

    // Packet landing exactly on the terminal-count edge.
    for (int i = 0; i < int'(R) && (t % R != R - 1); i++) idle(1);
    cycle(1, 1, 1, 0, 0, 0, 0, 1);
    idle(2 * R);

    // Framing errors on egress.
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1, 0, 1);
    idle(1);
    chk("frame_err_out", err_out, 8'h02);
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 0, 1, 0, 1);
    idle(1);
    chk("sat_err_out", err_out, 8'hFF);
    idle(R);

    // Clear beats a simultaneous packet on both ports.
    cycle(1, 1, 1, 1, 1, 1, 1, 1);
    idle(20);
    chk("clr_hex3", hex3, 8'h3F);
    chk("clr_hex6", hex6, 8'h3F);
    chk("clr_err_out", err_out, 8'h00);

    // Single packet then idle: dot timing covered by the scoreboard.
    cycle(1, 1, 1, 0, 0, 0, 0, 1);
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cycle(1, 1, 0, 1, 1, 0, 0, 1);
        async_reset();
      end
      cycle($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 3 == 0,
            $urandom % 4 != 0, $urandom % 3 == 0, $urandom % 3 == 0,
            $urandom % 128 == 0, 1);
    end
    idle(2);
    @(posedge clk50);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
